// File: rtl/dual_edge_alu_pipe.sv
// Two-stage ALU pipeline: stage 1 (a op1 b) on negedge, stage 2 (t op2 d / accumulate) on posedge,
// followed by PIPE posedge output registers. Define DUAL_EDGE_ALU_SINGLE_EDGE_EN to move stage 1 to posedge.
module dual_edge_alu_pipe #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op1,
    input  logic [1:0]       op2,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] d,
    input  logic             acc_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] f,
    output logic             ovf
);

    logic [WIDTH:0]   s1_sum, s1_dif;
    logic [WIDTH-1:0] t_d;
    logic             t_ovf_d;

    logic [WIDTH-1:0] t_q, d_q;
    logic [1:0]       op2_q;
    logic             t_valid_q, t_ovf_q;

    always_comb begin
        s1_sum  = {1'b0, a} + {1'b0, b};
        s1_dif  = {1'b0, a} - {1'b0, b};
        t_d     = '0;
        t_ovf_d = 1'b0;
        case (op1)
            2'b00:   t_d = a | b;
            2'b01:   t_d = a & b;
            2'b10: begin
                t_d     = s1_sum[WIDTH-1:0];
                t_ovf_d = s1_sum[WIDTH];
            end
            default: begin
                t_d     = s1_dif[WIDTH-1:0];
                t_ovf_d = s1_dif[WIDTH];
            end
        endcase
    end

    // Stage 1 gives the posedge stage a half cycle of pre-computed t.
`ifdef DUAL_EDGE_ALU_SINGLE_EDGE_EN
    always_ff @(posedge clk) begin
`else
    always_ff @(negedge clk) begin
`endif
        if (!rst_n) begin
            t_q       <= '0;
            t_ovf_q   <= 1'b0;
            t_valid_q <= 1'b0;
            d_q       <= '0;
            op2_q     <= 2'b00;
        end else begin
            t_valid_q <= in_valid;
            if (in_valid) begin
                t_q     <= t_d;
                t_ovf_q <= t_ovf_d;
                d_q     <= d;
                op2_q   <= op2;
            end
        end
    end

    logic [WIDTH:0]   s2_sum, s2_dif, s2_acc;
    logic [WIDTH-1:0] acc_base, r_d, acc_d;
    logic             r_c_d, ovf_d;

    logic [WIDTH-1:0] acc_q;
    logic             ovf_q;
    logic [WIDTH-1:0] pipe_f_q [0:PIPE];
    logic [PIPE:0]    pipe_v_q;

    // acc_clr acts before a coincident accumulate, so the result is a fresh acc = t.
    always_comb begin
        acc_base = acc_clr ? '0 : acc_q;
        s2_sum   = {1'b0, t_q} + {1'b0, d_q};
        s2_dif   = {1'b0, t_q} - {1'b0, d_q};
        s2_acc   = {1'b0, acc_base} + {1'b0, t_q};
        r_d      = '0;
        r_c_d    = 1'b0;
        case (op2_q)
            2'b00:   r_d = t_q & d_q;
            2'b01: begin
                r_d   = s2_dif[WIDTH-1:0];
                r_c_d = s2_dif[WIDTH];
            end
            2'b10: begin
                r_d   = s2_sum[WIDTH-1:0];
                r_c_d = s2_sum[WIDTH];
            end
            default: begin
                r_d   = s2_acc[WIDTH-1:0];
                r_c_d = s2_acc[WIDTH];
            end
        endcase
        acc_d = acc_base;
        if (t_valid_q && (op2_q == 2'b11)) begin
            acc_d = r_d;
        end
        ovf_d = (acc_clr ? 1'b0 : ovf_q) | (t_valid_q & (t_ovf_q | r_c_d));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            pipe_v_q <= '0;
            for (int i = 0; i <= PIPE; i++) begin
                pipe_f_q[i] <= '0;
            end
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            pipe_v_q[0] <= t_valid_q;
            if (t_valid_q) begin
                pipe_f_q[0] <= r_d;
            end
            // Data only moves with its valid, so f holds between results.
            for (int i = 1; i <= PIPE; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                if (pipe_v_q[i-1]) begin
                    pipe_f_q[i] <= pipe_f_q[i-1];
                end
            end
        end
    end

    assign f         = pipe_f_q[PIPE];
    assign out_valid = pipe_v_q[PIPE];
    assign ovf       = ovf_q;

endmodule
